// File: rtl/wdt_rst_gen.sv
`default_nettype none
// ============================================================================
//  Module      : wdt_rst_gen
//  Description : Two-stage watchdog producing a software-reset request.
//                The first missed deadline raises a level warning IRQ; a
//                second consecutive timeout fires a fixed-length reset pulse
//                towards the system reset controller (soft_rst_en input).
//                Firmware configures and feeds it through a 4-word register
//                port on the core clock.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1   core clock
//    rst_n      in   1   asynchronous active-low reset
//    we_i       in   1   register write strobe, one cycle per write
//    addr_i     in   4   byte address, [3:2] = 0 CTRL, 1 LOAD, 2 FEED, 3 CNT
//    wdata_i    in   32  write data
//    rdata_o    out  32  read data, combinational from addr_i
//    wdt_irq_o  out  1   warning interrupt (level, registered)
//    wdt_rst_o  out  1   reset request pulse (registered)
//  Register map
//    CTRL  : bit0 EN, bit1 LOCK (sticky); read-only bit3 irq, bits[5:4] state
//    LOAD  : reload value, a write of 0 stores 1
//    FEED  : write FEED_KEY to restart the count; reads 0
//    CNT   : current down-counter, read-only
// ============================================================================
module wdt_rst_gen #(
  parameter int unsigned CNT_W     = 32,
  parameter logic [31:0] LOAD_RST  = 32'h00FF_FFFF,
  parameter logic [31:0] FEED_KEY  = 32'h5A5A_A5A5,
  parameter int unsigned RST_PULSE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        wdt_irq_o,
  output logic        wdt_rst_o
);

  // Pulse counter only has to hold RST_PULSE-1.
  localparam int unsigned PW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;

  // Encoding is visible to software through CTRL[5:4].
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_WARN  = 2'd2,
    ST_FIRE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             en_q,    en_d;
  logic             lock_q,  lock_d;
  logic [CNT_W-1:0] load_q,  load_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             irq_q,   irq_d;
  logic             rst_q,   rst_d;
  logic [PW-1:0]    pulse_q, pulse_d;

  // --------------------------------------------------------------------------
  // Register-port decode
  // --------------------------------------------------------------------------
  logic wr_ctrl;
  logic wr_load;
  logic wr_feed;
  logic ctrl_ok;
  logic key_ok;
  logic unused_addr;

  assign wr_ctrl = we_i && (addr_i[3:2] == 2'd0);
  assign wr_load = we_i && (addr_i[3:2] == 2'd1);
  assign wr_feed = we_i && (addr_i[3:2] == 2'd2);
  // LOCK freezes CTRL and LOAD, but never the feed path.
  assign ctrl_ok = wr_ctrl && !lock_q;
  assign key_ok  = (wdata_i == FEED_KEY);
  // Byte-lane bits of the address carry no meaning for word registers.
  assign unused_addr = ^addr_i[1:0];

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      en_q    <= 1'b0;
      lock_q  <= 1'b0;
      load_q  <= LOAD_RST[CNT_W-1:0];
      cnt_q   <= '0;
      irq_q   <= 1'b0;
      rst_q   <= 1'b0;
      pulse_q <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      lock_q  <= lock_d;
      load_q  <= load_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq_d;
      rst_q   <= rst_d;
      pulse_q <= pulse_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // Per-cycle priority inside COUNT/WARN:
  //   wrong key > disable > valid feed > expiry > decrement
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    lock_d  = lock_q;
    load_d  = load_q;
    cnt_d   = cnt_q;
    irq_d   = irq_q;
    rst_d   = rst_q;
    pulse_d = pulse_q;

    // CTRL register update; the EN bit cannot be touched while a pulse runs
    // so a started reset request always completes.
    if (ctrl_ok) begin
      lock_d = lock_q | wdata_i[1];
      if (state_q != ST_FIRE) begin
        en_d = wdata_i[0];
      end
    end

    // New LOAD only matters at the next reload; zero would mean "fire now"
    // and is clamped to 1.
    if (wr_load && !lock_q) begin
      if (wdata_i[CNT_W-1:0] == '0) begin
        load_d = CNT_W'(1);
      end else begin
        load_d = wdata_i[CNT_W-1:0];
      end
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (ctrl_ok && wdata_i[0]) begin
          cnt_d   = load_q;
          state_d = ST_COUNT;
        end
      end

      ST_COUNT, ST_WARN: begin
        if (wr_feed && !key_ok) begin
          // Punitive: a bad key is treated as a runaway firmware.
          state_d = ST_FIRE;
          rst_d   = 1'b1;
          pulse_d = PW'(RST_PULSE - 1);
        end else if (ctrl_ok && !wdata_i[0]) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          irq_d   = 1'b0;
        end else if (wr_feed) begin
          // A feed landing on the expiry cycle still rescues the count.
          state_d = ST_COUNT;
          cnt_d   = load_q;
          irq_d   = 1'b0;
        end else if (cnt_q == '0) begin
          if (state_q == ST_COUNT) begin
            state_d = ST_WARN;
            cnt_d   = load_q;
            irq_d   = 1'b1;
          end else begin
            state_d = ST_FIRE;
            rst_d   = 1'b1;
            pulse_d = PW'(RST_PULSE - 1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_FIRE: begin
        // pulse_q counts the remaining high cycles after the current one.
        if (pulse_q == '0) begin
          state_d = ST_IDLE;
          rst_d   = 1'b0;
          irq_d   = 1'b0;
          en_d    = 1'b0;
          cnt_d   = '0;
        end else begin
          pulse_d = pulse_q - PW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Read mux
  // --------------------------------------------------------------------------
  logic [31:0] load_ext;
  logic [31:0] cnt_ext;

  always_comb begin
    load_ext             = '0;
    load_ext[CNT_W-1:0]  = load_q;
    cnt_ext              = '0;
    cnt_ext[CNT_W-1:0]   = cnt_q;
  end

  always_comb begin
    rdata_o = '0;
    case (addr_i[3:2])
      2'd0:    rdata_o = {26'd0, state_q, irq_q, 1'b0, lock_q, en_q};
      2'd1:    rdata_o = load_ext;
      2'd2:    rdata_o = '0;
      default: rdata_o = cnt_ext;
    endcase
  end

  assign wdt_irq_o = irq_q;
  assign wdt_rst_o = rst_q;

endmodule
`default_nettype wire

// File: tb/tb_wdt_rst_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wdt_rst_gen
//  Description : Directed self-checking bench for wdt_rst_gen. Expected
//                values are queued as stimulus is applied and popped when
//                the matching DUT observation is taken.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wdt_rst_gen;

  localparam logic [31:0] KEY      = 32'h5A5A_A5A5;
  localparam logic [31:0] LOAD_DEF = 32'h00FF_FFFF;
  localparam logic [3:0]  A_CTRL   = 4'h0;
  localparam logic [3:0]  A_LOAD   = 4'h4;
  localparam logic [3:0]  A_FEED   = 4'h8;
  localparam logic [3:0]  A_CNT    = 4'hC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we_i;
  logic [3:0]  addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        wdt_irq_o;
  logic        wdt_rst_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  wdt_rst_gen #(
    .CNT_W     (32),
    .LOAD_RST  (LOAD_DEF),
    .FEED_KEY  (KEY),
    .RST_PULSE (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (we_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .rdata_o   (rdata_o),
    .wdt_irq_o (wdt_irq_o),
    .wdt_rst_o (wdt_rst_o)
  );

  task automatic push(input string t, input logic [31:0] e);
    tag_q.push_back(t);
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=%h required=<queued value>", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%h required=%h", t, obs, e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    we_i    = 1'b1;
    addr_i  = a;
    wdata_i = d;
    @(posedge clk);
    #1;
    we_i    = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    addr_i = a;
    #1;
    d = rdata_o;
  endtask

  task automatic check_reg(input string t, input logic [3:0] a, input logic [31:0] e);
    logic [31:0] v;
    push(t, e);
    rd(a, v);
    pop_check(v);
  endtask

  function automatic logic [31:0] outs();
    return {30'd0, wdt_irq_o, wdt_rst_o};
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] v;

    rst_n   = 1'b0;
    we_i    = 1'b0;
    addr_i  = '0;
    wdata_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Reset state
    check_reg("rst_ctrl", A_CTRL, 32'h0);
    check_reg("rst_load", A_LOAD, LOAD_DEF);
    check_reg("rst_cnt",  A_CNT,  32'h0);
    push("rst_outs", 32'h0);
    pop_check(outs());

    // 1: unfed expiry, irq at E+11, reset pulse E+22..E+25
    wr(A_LOAD, 32'd10);
    check_reg("t1_load", A_LOAD, 32'd10);
    wr(A_CTRL, 32'h1);
    check_reg("t1_start_cnt",  A_CNT,  32'd10);
    check_reg("t1_start_ctrl", A_CTRL, 32'h11);
    for (int k = 1; k <= 30; k++) begin
      push("t1_outs", {30'd0, 1'(k >= 11 && k <= 25), 1'(k >= 22 && k <= 25)});
    end
    for (int k = 1; k <= 30; k++) begin
      step();
      pop_check(outs());
    end
    check_reg("t1_end_ctrl", A_CTRL, 32'h0);

    // 2: regular feeding every 8 cycles keeps everything quiet
    wr(A_CTRL, 32'h1);
    for (int c = 0; c < 100; c++) begin
      push("t2_cnt", (c % 8 == 7) ? 32'd10 : 32'(10 - (c % 8 + 1)));
      push("t2_outs", 32'h0);
    end
    for (int c = 0; c < 100; c++) begin
      if (c % 8 == 7) wr(A_FEED, KEY);
      else            step();
      rd(A_CNT, v);
      pop_check(v);
      pop_check(outs());
    end
    wr(A_CTRL, 32'h0);
    check_reg("t2_dis_ctrl", A_CTRL, 32'h0);
    check_reg("t2_dis_cnt",  A_CNT,  32'h0);

    // 3: feed after warning clears irq and restarts COUNT
    wr(A_CTRL, 32'h1);
    repeat (11) step();
    push("t3_irq", 32'h1);
    pop_check({31'd0, wdt_irq_o});
    wr(A_FEED, KEY);
    push("t3_irq_clr", 32'h0);
    pop_check({31'd0, wdt_irq_o});
    check_reg("t3_ctrl", A_CTRL, 32'h11);
    check_reg("t3_cnt",  A_CNT,  32'd10);

    // 4: wrong key fires a 4-cycle pulse immediately
    wr(A_FEED, 32'h1234_5678);
    check_reg("t4_ctrl_fire", A_CTRL, 32'h31);
    for (int i = 0; i <= 4; i++) begin
      push("t4_rst", (i < 4) ? 32'h1 : 32'h0);
    end
    pop_check({31'd0, wdt_rst_o});
    for (int i = 1; i <= 4; i++) begin
      step();
      pop_check({31'd0, wdt_rst_o});
    end
    check_reg("t4_end_ctrl", A_CTRL, 32'h0);

    // Feed on the cnt==0 cycle wins over expiry
    wr(A_CTRL, 32'h1);
    repeat (10) step();
    check_reg("cz_cnt0", A_CNT, 32'h0);
    wr(A_FEED, KEY);
    push("cz_irq", 32'h0);
    pop_check({31'd0, wdt_irq_o});
    check_reg("cz_cnt",  A_CNT,  32'd10);
    check_reg("cz_ctrl", A_CTRL, 32'h11);
    wr(A_CTRL, 32'h0);

    // LOAD of zero is clamped to one
    wr(A_LOAD, 32'h0);
    check_reg("load0", A_LOAD, 32'h1);
    wr(A_LOAD, 32'd10);

    // 5: LOCK freezes CTRL and LOAD, feed still works
    wr(A_CTRL, 32'h3);
    check_reg("t5_ctrl", A_CTRL, 32'h13);
    wr(A_CTRL, 32'h0);
    check_reg("t5_ctrl_locked", A_CTRL, 32'h13);
    wr(A_LOAD, 32'd3);
    check_reg("t5_load_locked", A_LOAD, 32'd10);
    wr(A_FEED, KEY);
    check_reg("t5_feed_cnt", A_CNT, 32'd10);

    // 6: async reset in the middle of the pulse
    for (int i = 0; i < 40 && wdt_rst_o !== 1'b1; i++) step();
    push("t6_fire", 32'h1);
    pop_check({31'd0, wdt_rst_o});
    step();
    rst_n = 1'b0;
    #1;
    push("t6_async_rst", 32'h0);
    pop_check(outs());
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_reg("t6_ctrl", A_CTRL, 32'h0);
    check_reg("t6_load", A_LOAD, LOAD_DEF);
    check_reg("t6_cnt",  A_CNT,  32'h0);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL sb_leftover observed=%0d required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
